// File: rtl/iob_axis2axi_wr_pkg.sv
// Shared constants for the AXI write master: FSM encodings, AXI field codes
// and the awsize helper.
package iob_axis2axi_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_awsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/iob_reg_r.sv
// Clock-enabled register with synchronous active-high reset to RST_VAL.
module iob_reg_r #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Reset wins over a low clock enable so a mid-burst abort is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            data_o <= RST_VAL;
        else if (cke_i)
            data_o <= data_i;
    end

endmodule

// File: rtl/iob_axis2axi_wr.sv
// AXI4 write master: takes one burst command, issues AW, streams exactly
// awlen+1 beats from AXI-Stream onto W, then waits for B.
module iob_axis2axi_wr
    import iob_axis2axi_wr_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic [AXI_ADDR_W-1:0]   w_addr_i,
    input  logic [AXI_LEN_W:0]      w_length_i,
    input  logic                    w_start_transfer_i,
    output logic                    w_busy_o,
    output logic                    w_error_o,
    input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
    input  logic                    axis_in_valid_i,
    output logic                    axis_in_ready_o,
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [AXI_DATA_W-1:0]   axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [AXI_ID_W-1:0]     axi_bid_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o
);

    localparam logic [AXI_LEN_W:0] MAX_LEN = {1'b1, {AXI_LEN_W{1'b0}}};

    logic [1:0]            state_q;
    wr_state_t             state, state_nxt;
    logic [AXI_ADDR_W-1:0] addr_q, addr_nxt;
    logic [AXI_LEN_W-1:0]  awlen_q, awlen_nxt;
    logic [AXI_LEN_W-1:0]  cnt_q, cnt_nxt;
    logic                  err_q, err_nxt;
    logic                  w_hs, last_beat;
    logic                  unused_bid;

    assign state      = wr_state_t'(state_q);
    assign w_hs       = (state == ST_DATA) && axis_in_valid_i && axi_wready_i;
    assign last_beat  = (cnt_q == awlen_q);
    assign unused_bid = ^axi_bid_i;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        awlen_nxt = awlen_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: if (w_start_transfer_i && (w_length_i != '0)) begin
                state_nxt = ST_ADDR;
                addr_nxt  = w_addr_i;
                // Oversized requests saturate at the longest legal burst.
                awlen_nxt = (w_length_i > MAX_LEN) ? '1
                          : AXI_LEN_W'(w_length_i - (AXI_LEN_W+1)'(1));
                cnt_nxt   = '0;
                err_nxt   = 1'b0;
            end
            ST_ADDR: if (axi_awready_i) state_nxt = ST_DATA;
            ST_DATA: if (w_hs) begin
                cnt_nxt = cnt_q + AXI_LEN_W'(1);
                if (last_beat) state_nxt = ST_RESP;
            end
            ST_RESP: if (axi_bvalid_i) begin
                state_nxt = ST_IDLE;
                if (axi_bresp_i != AXI_RESP_OKAY) err_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    iob_reg_r #(.DATA_W(2)) state_reg (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(state_nxt), .data_o(state_q)
    );
    iob_reg_r #(.DATA_W(AXI_ADDR_W)) addr_reg (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(addr_nxt), .data_o(addr_q)
    );
    iob_reg_r #(.DATA_W(AXI_LEN_W)) awlen_reg (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(awlen_nxt), .data_o(awlen_q)
    );
    iob_reg_r #(.DATA_W(AXI_LEN_W)) cnt_reg (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(cnt_nxt), .data_o(cnt_q)
    );
    iob_reg_r #(.DATA_W(1)) err_reg (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(err_nxt), .data_o(err_q)
    );

    assign w_busy_o        = (state != ST_IDLE);
    assign w_error_o       = err_q;
    assign axi_awid_o      = '0;
    assign axi_awaddr_o    = addr_q;
    assign axi_awlen_o     = awlen_q;
    assign axi_awsize_o    = axi_awsize(AXI_DATA_W);
    assign axi_awburst_o   = AXI_BURST_INCR;
    assign axi_awvalid_o   = (state == ST_ADDR);
    assign axi_wdata_o     = axis_in_data_i;
    assign axi_wstrb_o     = '1;
    assign axi_wlast_o     = last_beat;
    assign axi_wvalid_o    = (state == ST_DATA) && axis_in_valid_i;
    assign axis_in_ready_o = (state == ST_DATA) && axi_wready_i;
    assign axi_bready_o    = (state == ST_RESP);

endmodule

// File: tb/tb_iob_axis2axi_wr.sv
// Scoreboard bench for iob_axis2axi_wr: expected AW/W traffic is queued as
// stimulus is driven and matched against what the DUT puts on the bus.
module tb_iob_axis2axi_wr;

    localparam int AW = 32, DW = 32, LW = 8, IW = 1;

    logic clk = 1'b0, cke = 1'b1, rst = 1'b1;
    logic [AW-1:0] w_addr = '0;
    logic [LW:0]   w_length = '0;
    logic          w_start = 1'b0, w_busy, w_error;
    logic [DW-1:0] axis_data = '0;
    logic          axis_valid = 1'b0, axis_ready;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [LW-1:0] awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast, wvalid, wready = 1'b0;
    logic [IW-1:0] bid = '0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    iob_axis2axi_wr #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst),
        .w_addr_i(w_addr), .w_length_i(w_length), .w_start_transfer_i(w_start),
        .w_busy_o(w_busy), .w_error_o(w_error),
        .axis_in_data_i(axis_data), .axis_in_valid_i(axis_valid), .axis_in_ready_o(axis_ready),
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready)
    );

    typedef logic [AW+LW-1:0] aw_t;
    typedef logic [DW:0]      w_t;
    aw_t exp_aw[$], obs_aw[$];
    w_t  exp_w[$],  obs_w[$];
    int  checks = 0, failures = 0, data_ctr = 0;

    // Bus monitor: record every handshake the DUT completes.
    always @(posedge clk) begin
        if (!rst) begin
            if (awvalid && awready) obs_aw.push_back({awaddr, awlen});
            if (wvalid && wready)   obs_w.push_back({wlast, wdata});
        end
    end

    task automatic cyc;
        @(posedge clk); #1;
    endtask

    // Issues one start and services the burst; expected AW/W entries are
    // pushed from the bench's own clamp/beat model as stimulus is driven.
    task automatic run_burst(input logic [AW-1:0] addr, input logic [LW:0] len,
                             input logic [1:0] bresp_v, input bit stall, input int aw_delay,
                             input int abort_after, input bit restart,
                             output int sent, output int busy_cyc, output int aw_cyc,
                             output bit aw_bad, output bit early_rdy, output bit err_start,
                             output bit to);
        int eff;
        logic [LW-1:0] exp_len;
        bit hs, restarted;
        eff = (len > 9'd256) ? 256 : int'(len);
        exp_len = LW'(eff - 1);
        sent = 0; busy_cyc = 0; aw_cyc = 0; aw_bad = 0; early_rdy = 0; to = 1; restarted = 0;
        exp_aw.push_back({addr, exp_len});
        w_addr = addr; w_length = len; w_start = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = bresp_v; axis_valid = 1'b0;
        cyc;
        w_start = 1'b0;
        err_start = w_error;
        for (int k = 0; k < 3000; k++) begin
            if (!w_busy) begin to = 0; break; end
            busy_cyc++;
            awready    = (k >= aw_delay);
            wready     = stall ? (k % 2 == 0) : 1'b1;
            axis_valid = stall ? (k % 3 != 2) : 1'b1;
            axis_data  = DW'(32'hD000_0000 + data_ctr);
            if (restart && !restarted && sent == 2) begin
                w_start = 1'b1; w_addr = 32'h0000_DEA0; w_length = 9'd5; restarted = 1;
            end
            #1;
            if (awvalid) begin
                aw_cyc++;
                if (awaddr !== addr || awlen !== exp_len) aw_bad = 1;
                if (axis_ready) early_rdy = 1;
            end
            hs = axis_ready && axis_valid;
            if (hs) exp_w.push_back({(sent == eff - 1), axis_data});
            @(posedge clk); #1;
            w_start = 1'b0; w_addr = addr; w_length = len;
            if (hs) begin sent++; data_ctr++; end
            if (abort_after > 0 && sent == abort_after) begin to = 0; break; end
        end
        axis_valid = 1'b0; wready = 1'b0; awready = 1'b0; bvalid = 1'b0;
    endtask

    int sent, busy_cyc, aw_cyc;
    bit aw_bad, early_rdy, err_start, to;

    task automatic test_reset;
        rst = 1'b1;
        cyc; cyc;
        rst = 1'b0;
        #1;
        checks++; if ({w_busy, awvalid, wvalid, bready, axis_ready, w_error} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000",
                {w_busy, awvalid, wvalid, bready, axis_ready, w_error}); end
        checks++; if ({awaddr, awlen} !== '0) begin
            failures++; $display("FAIL reset_aw got=%h/%h exp=0/0", awaddr, awlen); end
        checks++; if ({awsize, awburst, wstrb, awid} !== {3'd2, 2'b01, 4'hF, 1'b0}) begin
            failures++; $display("FAIL const_outs got=%0d/%b/%h/%0d exp=2/01/f/0",
                awsize, awburst, wstrb, awid); end
        cyc;
    endtask

    task automatic test_single_beat;
        run_burst(32'h100, 9'd1, 2'b00, 0, 0, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (to !== 1'b0 || sent != 1) begin
            failures++; $display("FAIL single_beats got=%0d to=%0d exp=1", sent, to); end
        checks++; if (busy_cyc != 3) begin
            failures++; $display("FAIL single_busy got=%0d exp=3", busy_cyc); end
        checks++; if (w_error !== 1'b0 || aw_bad) begin
            failures++; $display("FAIL single_err_aw got=%b/%b exp=0/0", w_error, aw_bad); end
    endtask

    task automatic test_stalls;
        run_burst(32'h2000, 9'd16, 2'b00, 1, 0, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (to !== 1'b0 || sent != 16) begin
            failures++; $display("FAIL stall_beats got=%0d to=%0d exp=16", sent, to); end
        checks++; if (aw_bad || aw_cyc != 1) begin
            failures++; $display("FAIL stall_aw got=%0d/%0d exp=0/1", aw_bad, aw_cyc); end
    endtask

    task automatic test_slow_aw;
        run_burst(32'h3040, 9'd4, 2'b00, 0, 5, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (aw_cyc != 6) begin
            failures++; $display("FAIL slow_aw_cycles got=%0d exp=6", aw_cyc); end
        checks++; if (aw_bad || early_rdy) begin
            failures++; $display("FAIL slow_aw_stable got=%0d/%0d exp=0/0", aw_bad, early_rdy); end
        checks++; if (to !== 1'b0 || sent != 4) begin
            failures++; $display("FAIL slow_aw_beats got=%0d exp=4", sent); end
    endtask

    task automatic test_error_clamp;
        run_burst(32'h4000, 9'd2, 2'b10, 0, 0, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (w_error !== 1'b1) begin
            failures++; $display("FAIL err_set got=%b exp=1", w_error); end
        w_start = 1'b1; w_length = 9'd0; w_addr = 32'h5000;
        cyc;
        w_start = 1'b0;
        checks++; if ({w_busy, awvalid, w_error} !== 3'b001) begin
            failures++; $display("FAIL len0_ignored got=%b exp=001", {w_busy, awvalid, w_error}); end
        run_burst(32'h6000, 9'd300, 2'b00, 0, 0, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (err_start !== 1'b0) begin
            failures++; $display("FAIL err_clear got=%b exp=0", err_start); end
        checks++; if (aw_bad || sent != 256 || to) begin
            failures++; $display("FAIL clamp got aw_bad=%0d beats=%0d exp=0/256", aw_bad, sent); end
    endtask

    task automatic test_start_while_busy;
        int n0;
        n0 = obs_aw.size();
        run_burst(32'h7000, 9'd4, 2'b00, 0, 0, 0, 1, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        cyc;
        checks++; if (obs_aw.size() - n0 != 1 || w_busy !== 1'b0) begin
            failures++; $display("FAIL busy_start got aw=%0d busy=%b exp=1/0", obs_aw.size() - n0, w_busy); end
        checks++; if (sent != 4 || to) begin
            failures++; $display("FAIL busy_start_beats got=%0d exp=4", sent); end
    endtask

    task automatic test_reset_mid;
        run_burst(32'h8000, 9'd8, 2'b00, 0, 0, 3, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (sent != 3 || w_busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre got=%0d/%b exp=3/1", sent, w_busy); end
        rst = 1'b1;
        cyc;
        rst = 1'b0; axis_valid = 1'b1; wready = 1'b1;
        #1;
        checks++; if ({w_busy, wvalid, axis_ready, awvalid, bready} !== 5'b0) begin
            failures++; $display("FAIL rst_mid_idle got=%b exp=00000",
                {w_busy, wvalid, axis_ready, awvalid, bready}); end
        cyc;
        run_burst(32'h9000, 9'd2, 2'b00, 0, 0, 0, 0, sent, busy_cyc, aw_cyc, aw_bad, early_rdy, err_start, to);
        checks++; if (sent != 2 || to || busy_cyc != 4) begin
            failures++; $display("FAIL rst_mid_after got beats=%0d busy=%0d exp=2/4", sent, busy_cyc); end
    endtask

    task automatic test_scoreboard;
        checks++; if (obs_aw.size() != exp_aw.size()) begin
            failures++; $display("FAIL sb_aw_count got=%0d exp=%0d", obs_aw.size(), exp_aw.size()); end
        checks++; if (obs_w.size() != exp_w.size()) begin
            failures++; $display("FAIL sb_w_count got=%0d exp=%0d", obs_w.size(), exp_w.size()); end
        while (obs_aw.size() > 0 && exp_aw.size() > 0) begin
            aw_t o, e;
            o = obs_aw.pop_front(); e = exp_aw.pop_front();
            checks++; if (o !== e) begin
                failures++; $display("FAIL sb_aw got=%h exp=%h", o, e); end
        end
        while (obs_w.size() > 0 && exp_w.size() > 0) begin
            w_t o, e;
            o = obs_w.pop_front(); e = exp_w.pop_front();
            checks++; if (o !== e) begin
                failures++; $display("FAIL sb_w got=%h exp=%h", o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_single_beat;
        test_stalls;
        test_slow_aw;
        test_error_clamp;
        test_start_while_busy;
        test_reset_mid;
        cyc;
        test_scoreboard;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
